// File: rtl/cordic_pipe.sv
// Fully pipelined rotation-mode CORDIC: angle FIFO in, cos/sin FIFOs out.
// Quadrant pre-rotation covers [-pi, pi]; the whole pipe stalls on output backpressure.
module cordic_pipe #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_STAGES = 16,
    parameter int GUARD_BITS = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  empty,
    output logic                  cos_wr_en,
    input  logic                  cos_full,
    output logic [DATA_WIDTH-1:0] cos_data_out,
    output logic                  sin_wr_en,
    input  logic                  sin_full,
    output logic [DATA_WIDTH-1:0] sin_data_out,
    output logic                  busy
);
    localparam int W  = DATA_WIDTH;
    localparam int N  = NUM_STAGES;
    localparam int G  = GUARD_BITS;
    localparam int IW = W + G + 1;
    localparam real PI_R = 3.14159265358979323846;

    localparam logic signed [IW-1:0] PI_Z   = IW'($rtoi(PI_R * (2.0 ** (W - 3)) + 0.5));
    localparam logic signed [IW-1:0] HALF_Z = IW'($rtoi(PI_R / 2.0 * (2.0 ** (W - 3)) + 0.5));
    localparam logic signed [IW-1:0] X_INIT = IW'($rtoi(0.6072529350 * (2.0 ** (W - 2 + G)) + 0.5));
    localparam logic signed [IW:0]   RND    = (IW + 1)'((2 ** G) / 2);
    localparam logic signed [IW:0]   MAXV   = {{(IW - W + 2){1'b0}}, {(W - 1){1'b1}}};
    localparam logic signed [IW:0]   MINV   = -MAXV;

    function automatic logic [N*IW-1:0] atan_table();
        logic [N*IW-1:0] t;
        t = '0;
        for (int unsigned i = 0; i < N; i++)
            t[i*IW +: IW] = IW'($rtoi($atan(1.0 / (2.0 ** i)) * (2.0 ** (W - 3 + G)) + 0.5));
        return t;
    endfunction

    localparam logic [N*IW-1:0] ATAN = atan_table();

    // Drop the guard bits with round-to-nearest, then clamp to the symmetric output range.
    function automatic logic [W-1:0] sat_round(input logic signed [IW:0] v);
        logic signed [IW:0] t;
        t = (v + RND) >>> G;
        if (t > MAXV) return MAXV[W-1:0];
        if (t < MINV) return MINV[W-1:0];
        return t[W-1:0];
    endfunction

    logic signed [IW-1:0] x_r [0:N];
    logic signed [IW-1:0] y_r [0:N];
    logic signed [IW-1:0] z_r [0:N];
    logic signed [IW-1:0] x_n [1:N];
    logic signed [IW-1:0] y_n [1:N];
    logic signed [IW-1:0] z_n [1:N];
    logic [N:0]           neg_r;
    logic [N:0]           v_r;
    logic                 in_pending;
    logic                 adv;
    logic                 wr;
    logic signed [IW-1:0] z_in;
    logic signed [IW-1:0] z_adj;
    logic signed [IW-1:0] z_p;
    logic                 neg_p;
    logic signed [IW:0]   cx;
    logic signed [IW:0]   sy;

    assign adv   = !(v_r[N] && (cos_full || sin_full));
    assign rd_en = !reset && !empty && adv;
    assign wr    = !reset && v_r[N] && !cos_full && !sin_full;
    assign busy  = !reset && (in_pending || (|v_r));

    always_comb begin
        z_in  = {{(IW - W){data_in[W-1]}}, data_in};
        z_adj = z_in;
        neg_p = 1'b0;
        if (z_in > HALF_Z) begin
            z_adj = z_in - PI_Z;
            neg_p = 1'b1;
        end else if (z_in < -HALF_Z) begin
            z_adj = z_in + PI_Z;
            neg_p = 1'b1;
        end
        z_p = z_adj <<< G;
    end

    always_comb begin
        for (int unsigned i = 0; i < N; i++) begin
            if (!z_r[i][IW-1]) begin
                x_n[i+1] = x_r[i] - (y_r[i] >>> i);
                y_n[i+1] = y_r[i] + (x_r[i] >>> i);
                z_n[i+1] = z_r[i] - signed'(ATAN[i*IW +: IW]);
            end else begin
                x_n[i+1] = x_r[i] + (y_r[i] >>> i);
                y_n[i+1] = y_r[i] - (x_r[i] >>> i);
                z_n[i+1] = z_r[i] + signed'(ATAN[i*IW +: IW]);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            v_r        <= '0;
            in_pending <= 1'b0;
        end else if (adv) begin
            in_pending <= rd_en;
            v_r        <= {v_r[N-1:0], in_pending};
            neg_r      <= {neg_r[N-1:0], neg_p};
            x_r[0]     <= X_INIT;
            y_r[0]     <= '0;
            z_r[0]     <= z_p;
            for (int unsigned i = 1; i <= N; i++) begin
                x_r[i] <= x_n[i];
                y_r[i] <= y_n[i];
                z_r[i] <= z_n[i];
            end
        end
    end

    always_comb begin
        cx = {x_r[N][IW-1], x_r[N]};
        sy = {y_r[N][IW-1], y_r[N]};
        if (neg_r[N]) begin
            cx = -cx;
            sy = -sy;
        end
        cos_wr_en    = wr;
        sin_wr_en    = wr;
        cos_data_out = wr ? sat_round(cx) : '0;
        sin_data_out = wr ? sat_round(sy) : '0;
    end
endmodule

// File: tb/tb_cordic_pipe.sv
// Scoreboard bench for cordic_pipe: FIFO models around the DUT, real-valued sin/cos reference.
module tb_cordic_pipe;
    localparam int W = 16;
    localparam int N = 16;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         empty = 1'b1;
    logic         cos_full = 1'b0;
    logic         sin_full = 1'b0;
    logic [W-1:0] data_in = '0;
    logic         rd_en, cos_wr_en, sin_wr_en, busy;
    logic [W-1:0] cos_data_out, sin_data_out;

    cordic_pipe #(.DATA_WIDTH(W), .NUM_STAGES(N), .GUARD_BITS(2)) dut (
        .clock(clock), .reset(reset), .rd_en(rd_en), .data_in(data_in), .empty(empty),
        .cos_wr_en(cos_wr_en), .cos_full(cos_full), .cos_data_out(cos_data_out),
        .sin_wr_en(sin_wr_en), .sin_full(sin_full), .sin_data_out(sin_data_out),
        .busy(busy)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct { int c; int s; int tol_s; int rd_cyc; } exp_t;
    exp_t exp_q[$];
    int   in_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   lat_check = 1'b1;

    task automatic chk(input string name, input bit ok, input int act, input int req);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, req, $time);
    endtask

    function automatic int rnd(input real r);
        return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Angle is Q3.13 radians; outputs are Q2.14.
    function automatic exp_t model(input int a, input int rc);
        exp_t e;
        real  th;
        th       = a / 8192.0;
        e.c      = rnd($cos(th) * 16384.0);
        e.s      = rnd($sin(th) * 16384.0);
        e.tol_s  = (a >= 25736 || a <= -25736) ? 6 : 4;
        e.rd_cyc = rc;
        return e;
    endfunction

    // Input FIFO: a read strobe seen in a cycle presents the next angle just after the edge.
    initial begin
        bit rd_s;
        int rc, a;
        forever begin
            @(negedge clock);
            rd_s = rd_en;
            rc   = cyc;
            @(posedge clock);
            #1;
            if (rd_s) begin
                if (in_q.size() > 0) begin
                    a       = in_q.pop_front();
                    data_in = W'(a);
                    exp_q.push_back(model(a, rc));
                end else begin
                    chk("rd_when_empty", 1'b0, 1, 0);
                end
            end
            empty = (in_q.size() == 0);
        end
    end

    initial begin
        exp_t e;
        int   ac, as_v;
        forever begin
            @(negedge clock);
            if (cos_wr_en || sin_wr_en) begin
                chk("wr_pair", cos_wr_en == sin_wr_en, int'(sin_wr_en), int'(cos_wr_en));
                if (exp_q.size() == 0) begin
                    chk("unexpected_wr", 1'b0, 1, 0);
                end else begin
                    e    = exp_q.pop_front();
                    ac   = int'($signed(cos_data_out));
                    as_v = int'($signed(sin_data_out));
                    chk("cos", iabs(ac - e.c) <= 4, ac, e.c);
                    chk("sin", iabs(as_v - e.s) <= e.tol_s, as_v, e.s);
                    if (lat_check) chk("latency", (cyc - e.rd_cyc) == N + 2, cyc - e.rd_cyc, N + 2);
                end
            end else begin
                chk("idle_zero", cos_data_out == '0 && sin_data_out == '0,
                    int'(cos_data_out) + int'(sin_data_out), 0);
            end
        end
    end

    task automatic wait_drain();
        bit done;
        done = 1'b0;
        for (int k = 0; k < 400 && !done; k++) begin
            @(negedge clock);
            if (in_q.size() == 0 && exp_q.size() == 0 && !busy) done = 1'b1;
        end
        chk("drain", done, exp_q.size(), 0);
    endtask

    task automatic at_drive();
        @(posedge clock);
        #2;
    endtask

    initial begin
        int directed[4];
        directed = '{6434, -12868, 25736, -25736};

        in_q.push_back(0);
        repeat (3) begin
            @(negedge clock);
            chk("rst_rd_en", rd_en == 1'b0, int'(rd_en), 0);
            chk("rst_wr", !cos_wr_en && !sin_wr_en, int'(cos_wr_en), 0);
            chk("rst_busy", busy == 1'b0, int'(busy), 0);
        end
        at_drive();
        reset = 1'b0;
        wait_drain();

        at_drive();
        foreach (directed[i]) in_q.push_back(directed[i]);
        wait_drain();

        at_drive();
        for (int i = 0; i < 64; i++) in_q.push_back(int'($urandom_range(0, 51472)) - 25736);
        wait_drain();

        lat_check = 1'b0;
        at_drive();
        for (int i = 0; i < 60; i++) in_q.push_back(int'($urandom_range(0, 51472)) - 25736);
        repeat (30) @(posedge clock);
        #2;
        sin_full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            chk("stall_rd_en", rd_en == 1'b0, int'(rd_en), 0);
            chk("stall_wr", !cos_wr_en && !sin_wr_en, int'(cos_wr_en), 0);
        end
        at_drive();
        sin_full = 1'b0;
        @(negedge clock);
        chk("resume_wr", cos_wr_en == 1'b1 && sin_wr_en == 1'b1, int'(cos_wr_en), 1);
        wait_drain();
        lat_check = 1'b1;

        at_drive();
        for (int i = 0; i < 40; i++) in_q.push_back(int'($urandom_range(0, 51472)) - 25736);
        repeat (15) @(posedge clock);
        #2;
        reset = 1'b1;
        exp_q.delete();
        repeat (2) begin
            @(negedge clock);
            chk("midrst_rd_en", rd_en == 1'b0, int'(rd_en), 0);
            chk("midrst_wr", !cos_wr_en && !sin_wr_en, int'(cos_wr_en), 0);
            chk("midrst_busy", busy == 1'b0, int'(busy), 0);
        end
        at_drive();
        reset = 1'b0;
        @(negedge clock);
        chk("busy_after_rst", busy == 1'b0, int'(busy), 0);
        wait_drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, want finish");
        $fatal(1, "timeout");
    end
endmodule
